// File: rtl/y86_pkg.sv
// Shared Y86 pipeline constants: status codes, register ids, instruction codes,
// plus the writeback scheduler state encoding.
package y86_pkg;

    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        WB_RUN    = 2'd0,
        WB_DRAIN  = 2'd1,
        WB_HALTED = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_pend_queue.sv
// Pending register-write FIFO: up to two pushes and one pop per cycle, with two
// associative lookup ports returning the youngest pending value for a register id.
module wb_pend_queue
    import y86_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 push_cnt,
    input  logic [3:0]                 push_id0,
    input  logic [DW-1:0]              push_val0,
    input  logic [3:0]                 push_id1,
    input  logic [DW-1:0]              push_val1,
    input  logic                       pop,
    output logic [3:0]                 head_id,
    output logic [DW-1:0]              head_val,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [1:0][3:0]            lk_src,
    output logic [1:0]                 lk_hit,
    output logic [1:0][DW-1:0]         lk_val
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    ids_reg  [DEPTH];
    logic [DW-1:0] vals_reg [DEPTH];
    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic          do_pop;

    assign do_pop   = pop && (count_reg != '0);
    assign head_id  = ids_reg[head_reg];
    assign head_val = vals_reg[head_reg];
    assign count    = count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            tail_reg  <= tail_reg + AW'(push_cnt);
            head_reg  <= head_reg + AW'(do_pop);
            count_reg <= count_reg + CW'(push_cnt) - CW'(do_pop);
        end
    end

    // Storage carries no reset; validity is defined purely by head/count.
    always_ff @(posedge clk) begin
        if (push_cnt != 2'd0) begin
            ids_reg[tail_reg]  <= push_id0;
            vals_reg[tail_reg] <= push_val0;
        end
        if (push_cnt == 2'd2) begin
            ids_reg[tail_reg + AW'(1)]  <= push_id1;
            vals_reg[tail_reg + AW'(1)] <= push_val1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lookup
            logic          hit;
            logic [DW-1:0] val;

            // Walk oldest to youngest so the last match wins.
            always_comb begin
                logic [AW-1:0] idx;
                hit = 1'b0;
                val = '0;
                idx = head_reg;
                for (int i = 0; i < DEPTH; i++) begin
                    idx = head_reg + AW'(i);
                    if ((CW'(i) < count_reg) && (lk_src[gi] != REG_NONE) &&
                        (ids_reg[idx] == lk_src[gi])) begin
                        hit = 1'b1;
                        val = vals_reg[idx];
                    end
                end
            end

            assign lk_hit[gi] = hit;
            assign lk_val[gi] = val;
        end
    endgenerate

endmodule

// File: rtl/regfile_write_scheduler.sv
// Writeback scheduler: turns W-stage instructions into queued register writes,
// drains one per cycle to the register file and stops after a non-AOK status.
module regfile_write_scheduler
    import y86_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          W_valid,
    output logic          W_ready,
    input  logic [3:0]    W_stat,
    input  logic [3:0]    W_destE,
    input  logic [3:0]    W_destM,
    input  logic [DW-1:0] W_valE,
    input  logic [DW-1:0] W_valM,
    output logic          rf_we,
    output logic [3:0]    rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic [3:0]    srcA,
    output logic          fwdA_hit,
    output logic [DW-1:0] fwdA_val,
    input  logic [3:0]    srcB,
    output logic          fwdB_hit,
    output logic [DW-1:0] fwdB_val,
    output logic [3:0]    stat_out,
    output logic          halted
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_state_e         state_reg;
    wb_state_e         state_next;
    logic [3:0]        stat_reg;
    logic [CW-1:0]     count;
    logic              accept;
    logic              has_e;
    logic              has_m;
    logic              enq;
    logic [1:0]        push_cnt;
    logic [3:0]        head_id;
    logic [DW-1:0]     head_val;
    logic [1:0]        lk_hit;
    logic [1:0][DW-1:0] lk_val;

    assign W_ready = (state_reg == WB_RUN) && ((CW'(DEPTH) - count) >= CW'(2));
    assign accept  = W_valid && W_ready;
    assign has_e   = (W_destE != REG_NONE);
    assign has_m   = (W_destM != REG_NONE);
    assign enq     = accept && (W_stat == STAT_AOK);
    assign push_cnt = enq ? (2'(has_e) + 2'(has_m)) : 2'd0;

    // Slot 0 takes the E write when present, otherwise the M write; slot 1 is
    // only used when both exist, keeping M younger than E.
    wb_pend_queue #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push_cnt  (push_cnt),
        .push_id0  (has_e ? W_destE : W_destM),
        .push_val0 (has_e ? W_valE  : W_valM),
        .push_id1  (W_destM),
        .push_val1 (W_valM),
        .pop       (rf_we),
        .head_id   (head_id),
        .head_val  (head_val),
        .count     (count),
        .lk_src    ({srcB, srcA}),
        .lk_hit    (lk_hit),
        .lk_val    (lk_val)
    );

    assign rf_we    = (count != '0) && (state_reg != WB_HALTED);
    assign rf_waddr = rf_we ? head_id  : 4'd0;
    assign rf_wdata = rf_we ? head_val : '0;

    assign fwdA_hit = lk_hit[0];
    assign fwdA_val = lk_val[0];
    assign fwdB_hit = lk_hit[1];
    assign fwdB_val = lk_val[1];

    assign stat_out = stat_reg;
    assign halted   = (state_reg == WB_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= WB_RUN;
            stat_reg  <= STAT_AOK;
        end else begin
            state_reg <= state_next;
            if (accept && (W_stat != STAT_AOK)) begin
                stat_reg <= W_stat;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WB_RUN: begin
                if (accept && (W_stat != STAT_AOK)) begin
                    state_next = WB_DRAIN;
                end
            end
            WB_DRAIN: begin
                if (count == '0) begin
                    state_next = WB_HALTED;
                end
            end
            WB_HALTED: state_next = WB_HALTED;
            default:   state_next = WB_RUN;
        endcase
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: one task per scenario with inline checks.
module tb_regfile_write_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        W_valid;
    logic        W_ready;
    logic [3:0]  W_stat;
    logic [3:0]  W_destE;
    logic [3:0]  W_destM;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [3:0]  srcA;
    logic        fwdA_hit;
    logic [63:0] fwdA_val;
    logic [3:0]  srcB;
    logic        fwdB_hit;
    logic [63:0] fwdB_val;
    logic [3:0]  stat_out;
    logic        halted;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_write_scheduler #(.DEPTH(4), .DW(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .W_valid  (W_valid),
        .W_ready  (W_ready),
        .W_stat   (W_stat),
        .W_destE  (W_destE),
        .W_destM  (W_destM),
        .W_valE   (W_valE),
        .W_valM   (W_valM),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .srcA     (srcA),
        .fwdA_hit (fwdA_hit),
        .fwdA_val (fwdA_val),
        .srcB     (srcB),
        .fwdB_hit (fwdB_hit),
        .fwdB_val (fwdB_val),
        .stat_out (stat_out),
        .halted   (halted)
    );

    task automatic drive(input logic v, input logic [3:0] st, input logic [3:0] de,
                         input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
        W_valid = v;
        W_stat  = st;
        W_destE = de;
        W_valE  = ve;
        W_destM = dm;
        W_valM  = vm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0);
        srcA = 4'hF;
        srcB = 4'hF;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0d exp=0", rf_we); end
        checks++; if (rf_waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
        checks++; if (rf_wdata !== 64'd0) begin errors++; $display("FAIL reset_wdata got=%0h exp=0", rf_wdata); end
        checks++; if (stat_out !== 4'd1) begin errors++; $display("FAIL reset_stat got=%0d exp=1", stat_out); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%0d exp=0", halted); end
        checks++; if (W_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0d exp=1", W_ready); end
        $display("test_reset done");
    endtask

    task automatic test_single_write();
        do_reset();
        srcA = 4'd3;
        drive(1'b1, 4'd1, 4'd3, 64'd5, 4'hF, 64'd0);
        #1;
        checks++; if (fwdA_hit !== 1'b0) begin errors++; $display("FAIL single_arrival_hidden got=%0d exp=0", fwdA_hit); end
        tick();
        drive(1'b0, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0);
        #1;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we got=%0d exp=1", rf_we); end
        checks++; if (rf_waddr !== 4'd3) begin errors++; $display("FAIL single_waddr got=%0d exp=3", rf_waddr); end
        checks++; if (rf_wdata !== 64'd5) begin errors++; $display("FAIL single_wdata got=%0h exp=5", rf_wdata); end
        checks++; if (fwdA_hit !== 1'b1 || fwdA_val !== 64'd5) begin errors++; $display("FAIL single_fwd got=%0d/%0h exp=1/5", fwdA_hit, fwdA_val); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we_after got=%0d exp=0", rf_we); end
        $display("test_single_write done");
    endtask

    task automatic test_popq();
        do_reset();
        srcA = 4'd4;
        drive(1'b1, 4'd1, 4'd4, 64'h108, 4'd4, 64'h77);
        tick();
        drive(1'b0, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0);
        #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd4 || rf_wdata !== 64'h108) begin errors++; $display("FAIL popq_w1 got=%0d/%0d/%0h exp=1/4/108", rf_we, rf_waddr, rf_wdata); end
        checks++; if (fwdA_hit !== 1'b1 || fwdA_val !== 64'h77) begin errors++; $display("FAIL popq_fwd1 got=%0d/%0h exp=1/77", fwdA_hit, fwdA_val); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd4 || rf_wdata !== 64'h77) begin errors++; $display("FAIL popq_w2 got=%0d/%0d/%0h exp=1/4/77", rf_we, rf_waddr, rf_wdata); end
        checks++; if (fwdA_hit !== 1'b1 || fwdA_val !== 64'h77) begin errors++; $display("FAIL popq_fwd2 got=%0d/%0h exp=1/77", fwdA_hit, fwdA_val); end
        tick();
        checks++; if (rf_we !== 1'b0 || fwdA_hit !== 1'b0) begin errors++; $display("FAIL popq_empty got=%0d/%0d exp=0/0", rf_we, fwdA_hit); end
        $display("test_popq done");
    endtask

    task automatic test_back_to_back();
        int st_e      [8] = '{1, 3, 6, 6, 0, 0, 0, 0};
        int st_m      [8] = '{2, 5, 7, 7, 0, 0, 0, 0};
        int exp_ready [8] = '{1, 1, 0, 1, 0, 1, 1, 1};
        int exp_addr  [8] = '{0, 1, 2, 3, 5, 6, 7, 0};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (st_e[c] != 0)
                drive(1'b1, 4'd1, 4'(st_e[c]), 64'(st_e[c] * 10), 4'(st_m[c]), 64'(st_m[c] * 10));
            else
                drive(1'b0, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0);
            #1;
            checks++; if (W_ready !== 1'(exp_ready[c])) begin errors++; $display("FAIL b2b_ready c=%0d got=%0d exp=%0d", c, W_ready, exp_ready[c]); end
            checks++;
            if (rf_we !== (exp_addr[c] != 0) || rf_waddr !== 4'(exp_addr[c]) || rf_wdata !== 64'(exp_addr[c] * 10)) begin
                errors++;
                $display("FAIL b2b_write c=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c, rf_we, rf_waddr, rf_wdata,
                         exp_addr[c] != 0, exp_addr[c], exp_addr[c] * 10);
            end
            tick();
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_halt();
        do_reset();
        drive(1'b1, 4'd1, 4'd1, 64'd11, 4'd2, 64'd22);
        tick();
        drive(1'b1, 4'd2, 4'hF, 64'd0, 4'hF, 64'd0);
        #1;
        checks++; if (rf_waddr !== 4'd1 || rf_wdata !== 64'd11) begin errors++; $display("FAIL halt_w1 got=%0d/%0d exp=1/11", rf_waddr, rf_wdata); end
        tick();
        drive(1'b1, 4'd1, 4'd8, 64'd88, 4'hF, 64'd0);
        #1;
        checks++; if (W_ready !== 1'b0) begin errors++; $display("FAIL halt_ready got=%0d exp=0", W_ready); end
        checks++; if (stat_out !== 4'd2) begin errors++; $display("FAIL halt_stat got=%0d exp=2", stat_out); end
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd2 || rf_wdata !== 64'd22) begin errors++; $display("FAIL halt_w2 got=%0d/%0d/%0d exp=1/2/22", rf_we, rf_waddr, rf_wdata); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early got=%0d exp=0", halted); end
        tick();
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted got=%0d exp=1", halted); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (rf_we !== 1'b0 || W_ready !== 1'b0) begin errors++; $display("FAIL halt_ignore c=%0d got=%0d/%0d exp=0/0", c, rf_we, W_ready); end
            tick();
        end
        checks++; if (stat_out !== 4'd2) begin errors++; $display("FAIL halt_stat_hold got=%0d exp=2", stat_out); end
        $display("test_halt done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        checks++; if (halted !== 1'b0 || stat_out !== 4'd1) begin errors++; $display("FAIL rmid_clear_halt got=%0d/%0d exp=0/1", halted, stat_out); end
        drive(1'b1, 4'd1, 4'd1, 64'd10, 4'd2, 64'd20);
        tick();
        drive(1'b1, 4'd1, 4'd3, 64'd30, 4'd5, 64'd50);
        tick();
        drive(1'b0, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0);
        srcA = 4'd5;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rmid_we got=%0d exp=0", rf_we); end
        checks++; if (W_ready !== 1'b1 || stat_out !== 4'd1 || halted !== 1'b0) begin errors++; $display("FAIL rmid_state got=%0d/%0d/%0d exp=1/1/0", W_ready, stat_out, halted); end
        checks++; if (fwdA_hit !== 1'b0) begin errors++; $display("FAIL rmid_fwd got=%0d exp=0", fwdA_hit); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rmid_we2 got=%0d exp=0", rf_we); end
        $display("test_reset_mid done");
    endtask

    task automatic test_lookup();
        do_reset();
        drive(1'b1, 4'd1, 4'd3, 64'd33, 4'd5, 64'd55);
        tick();
        drive(1'b0, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0);
        srcA = 4'd3;
        srcB = 4'hF;
        #1;
        checks++; if (fwdB_hit !== 1'b0 || fwdB_val !== 64'd0) begin errors++; $display("FAIL lk_none got=%0d/%0h exp=0/0", fwdB_hit, fwdB_val); end
        checks++; if (fwdA_hit !== 1'b1 || fwdA_val !== 64'd33) begin errors++; $display("FAIL lk_head got=%0d/%0d exp=1/33", fwdA_hit, fwdA_val); end
        srcB = 4'd7;
        #1;
        checks++; if (fwdB_hit !== 1'b0 || fwdB_val !== 64'd0) begin errors++; $display("FAIL lk_absent got=%0d/%0h exp=0/0", fwdB_hit, fwdB_val); end
        srcB = 4'd5;
        #1;
        checks++; if (fwdB_hit !== 1'b1 || fwdB_val !== 64'd55) begin errors++; $display("FAIL lk_tail got=%0d/%0d exp=1/55", fwdB_hit, fwdB_val); end
        tick();
        tick();
        $display("test_lookup done");
    endtask

    initial begin
        rst = 1'b1;
        srcA = 4'hF;
        srcB = 4'hF;
        drive(1'b0, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0);
        test_reset();
        test_single_write();
        test_popq();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        test_lookup();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
